// File: rtl/uart_rx_cfg_if.sv
// Receive-side handshake between uart_rx_cfg and the register block that pops characters.
// The receiver drives through the master modport and the consumer uses the slave modport.
interface uart_rx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic                 o_Rx_Valid;
  logic                 i_Rx_Ready;
  logic [DATA_BITS-1:0] o_Rx_Byte;
  logic                 o_Parity_Err;
  logic                 o_Frame_Err;

  modport master (
    output o_Rx_Valid,
    output o_Rx_Byte,
    output o_Parity_Err,
    output o_Frame_Err,
    input  i_Rx_Ready
  );

  modport slave (
    input  o_Rx_Valid,
    input  o_Rx_Byte,
    input  o_Parity_Err,
    input  o_Frame_Err,
    output i_Rx_Ready
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: runtime divisor, 5..9 data bits, optional parity, 1/2 stop bits,
// parity/framing/break/overrun detection, and a small first-word-fall-through receive FIFO.
module uart_rx_cfg #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Rx_Serial,
  input  logic [CNT_W-1:0] i_Clks_Per_Bit,
  input  logic             i_Parity_En,
  input  logic             i_Parity_Odd,
  input  logic             i_Two_Stop,
  uart_rx_cfg_if.master    rx_bus,
  output logic             o_Overrun,
  output logic             o_Break,
  output logic             o_Busy
);
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W  = PTR_W + 1;
  localparam int unsigned IDX_W   = $clog2(DATA_BITS);
  localparam int unsigned ENTRY_W = DATA_BITS + 2;
  localparam logic [CNT_W-1:0] D_MIN = CNT_W'(4);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BRK_WAIT
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_rx_meta, r_rxs;
  logic [CNT_W-1:0]     r_cnt, r_d;
  logic                 r_par_en, r_par_odd, r_two_stop;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_par_bit, r_par_err, r_frame_err, r_stop_low;

  logic w_tick, w_half, w_cnt_clr, w_cnt_inc, w_latch;
  logic w_data_smp, w_par_smp, w_stop1_smp, w_complete;
  logic w_brk, w_push, w_frame_err_fin, w_stops_low;

  // FIFO storage and head/output registers
  logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [FCNT_W-1:0]  r_fcnt, w_fcnt_nxt;
  logic [ENTRY_W-1:0] w_push_entry, w_head_nxt, r_head;
  logic               w_full, w_pop, w_wr_en, w_ovr;
  logic               r_valid, r_overrun, r_break, r_busy;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= i_Rx_Serial;
      r_rxs     <= r_rx_meta;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  assign w_tick          = (r_cnt == (r_d - CNT_W'(1)));
  assign w_half          = (r_cnt == ((r_d - CNT_W'(1)) >> 1));
  assign w_frame_err_fin = r_frame_err | ~r_rxs;
  assign w_stops_low     = ~r_rxs & ((r_state == S_STOP2) ? r_stop_low : 1'b1);
  assign w_brk           = (r_data == '0) & (~r_par_en | ~r_par_bit) & w_stops_low;
  assign w_push          = w_complete & ~w_brk;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_latch     = 1'b0;
    w_data_smp  = 1'b0;
    w_par_smp   = 1'b0;
    w_stop1_smp = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rxs) begin
          w_latch     = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_half) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = r_rxs ? S_IDLE : S_DATA;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_cnt_clr  = 1'b1;
          w_data_smp = 1'b1;
          if (r_idx == IDX_W'(DATA_BITS - 1)) w_state_nxt = r_par_en ? S_PARITY : S_STOP1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_cnt_clr   = 1'b1;
          w_par_smp   = 1'b1;
          w_state_nxt = S_STOP1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_STOP1: begin
        if (w_tick) begin
          w_cnt_clr   = 1'b1;
          w_stop1_smp = 1'b1;
          if (r_two_stop) w_state_nxt = S_STOP2;
          else            w_complete  = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_STOP2: begin
        if (w_tick) begin
          w_cnt_clr  = 1'b1;
          w_complete = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_BRK_WAIT: begin
        if (r_rxs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Final stop sample decides between a break and a normal character
    if (w_complete) w_state_nxt = w_brk ? S_BRK_WAIT : S_IDLE;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_cnt       <= '0;
      r_d         <= D_MIN;
      r_par_en    <= 1'b0;
      r_par_odd   <= 1'b0;
      r_two_stop  <= 1'b0;
      r_idx       <= '0;
      r_data      <= '0;
      r_par_bit   <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_stop_low  <= 1'b0;
    end else begin
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
      if (w_latch) begin
        r_d         <= (i_Clks_Per_Bit < D_MIN) ? D_MIN : i_Clks_Per_Bit;
        r_par_en    <= i_Parity_En;
        r_par_odd   <= i_Parity_Odd;
        r_two_stop  <= i_Two_Stop;
        r_idx       <= '0;
        r_data      <= '0;
        r_par_bit   <= 1'b0;
        r_par_err   <= 1'b0;
        r_frame_err <= 1'b0;
        r_stop_low  <= 1'b0;
      end
      if (w_data_smp) begin
        r_data[r_idx] <= r_rxs;
        r_idx         <= r_idx + IDX_W'(1);
      end
      if (w_par_smp) begin
        r_par_bit <= r_rxs;
        r_par_err <= ((^r_data) ^ r_rxs) != r_par_odd;
      end
      if (w_stop1_smp) begin
        r_frame_err <= ~r_rxs;
        r_stop_low  <= ~r_rxs;
      end
    end
  end

  assign w_push_entry = {r_par_err, w_frame_err_fin, r_data};
  assign w_full       = (r_fcnt == FCNT_W'(FIFO_DEPTH));
  assign w_pop        = r_valid & rx_bus.i_Rx_Ready;
  assign w_wr_en      = w_push & (~w_full | w_pop);
  assign w_ovr        = w_push & w_full & ~w_pop;
  assign w_rd_nxt     = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;

  // Next head: bypass the entry being written when it lands at the new read pointer
  always_comb begin
    w_fcnt_nxt = r_fcnt;
    case ({w_wr_en, w_pop})
      2'b10:   w_fcnt_nxt = r_fcnt + FCNT_W'(1);
      2'b01:   w_fcnt_nxt = r_fcnt - FCNT_W'(1);
      default: w_fcnt_nxt = r_fcnt;
    endcase
    w_head_nxt = '0;
    if (w_fcnt_nxt != '0) begin
      w_head_nxt = (w_wr_en && (r_wr_ptr == w_rd_nxt)) ? w_push_entry : r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge i_Clock) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_push_entry;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_fcnt    <= '0;
      r_valid   <= 1'b0;
      r_head    <= '0;
      r_overrun <= 1'b0;
      r_break   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr  <= w_rd_nxt;
      r_fcnt    <= w_fcnt_nxt;
      r_valid   <= (w_fcnt_nxt != '0);
      r_head    <= w_head_nxt;
      r_overrun <= w_ovr;
      r_break   <= w_complete & w_brk;
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  assign rx_bus.o_Rx_Valid   = r_valid;
  assign rx_bus.o_Rx_Byte    = r_head[DATA_BITS-1:0];
  assign rx_bus.o_Frame_Err  = r_head[DATA_BITS];
  assign rx_bus.o_Parity_Err = r_head[DATA_BITS+1];
  assign o_Overrun           = r_overrun;
  assign o_Break             = r_break;
  assign o_Busy              = r_busy;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: table of single frames plus hand-written overrun,
// break, glitch and mid-frame reset sequences, all checked through an expected/observed scoreboard.
module tb_uart_rx_cfg;
  localparam int unsigned DW = 8;

  typedef logic [DW+1:0] ent_t;

  typedef struct {
    int          bclk;
    logic [15:0] cpb;
    bit          pen;
    bit          podd;
    bit          two;
    logic [7:0]  data;
    bit          pbit;
    bit          s1;
    bit          s2;
    ent_t        want;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_line;
  logic [15:0] cpb;
  logic        par_en, par_odd, two_stop;
  logic        ovr, brk, busy;

  uart_rx_cfg_if #(.DATA_BITS(DW)) rx_bus ();

  uart_rx_cfg #(.DATA_BITS(DW), .CNT_W(16), .FIFO_DEPTH(4)) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Rx_Serial    (rx_line),
    .i_Clks_Per_Bit (cpb),
    .i_Parity_En    (par_en),
    .i_Parity_Odd   (par_odd),
    .i_Two_Stop     (two_stop),
    .rx_bus         (rx_bus),
    .o_Overrun      (ovr),
    .o_Break        (brk),
    .o_Busy         (busy)
  );

  always #5 clk = ~clk;

  ent_t sb_q[$];
  ent_t obs_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ovr_cnt = 0;
  int   brk_cnt = 0;
  int   vhi_cnt = 0;
  int   rise_cyc = 0;
  int   start_cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe pops and pulses half a cycle away from the active edge
  always @(negedge clk) begin
    if (ovr) ovr_cnt <= ovr_cnt + 1;
    if (brk) brk_cnt <= brk_cnt + 1;
    if (rx_bus.o_Rx_Valid) vhi_cnt <= vhi_cnt + 1;
    if (rx_bus.o_Rx_Valid && !prev_valid) rise_cyc <= cyc;
    prev_valid <= rx_bus.o_Rx_Valid;
    if (rx_bus.o_Rx_Valid && rx_bus.i_Rx_Ready)
      obs_q.push_back({rx_bus.o_Parity_Err, rx_bus.o_Frame_Err, rx_bus.o_Rx_Byte});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx_line = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int bclk, input logic [7:0] data, input bit pen, input bit pbit,
                            input bit two, input bit s1, input bit s2);
    start_cyc = cyc;
    hold(1'b0, bclk);
    for (int i = 0; i < 8; i++) hold(data[i], bclk);
    if (pen) hold(pbit, bclk);
    hold(s1, bclk);
    if (two) hold(s2, bclk);
    hold(1'b1, 2 * bclk);
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while (obs_q.size() < sb_q.size() && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (obs_q.size() < sb_q.size()) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d entries want %0d", name, obs_q.size(), sb_q.size());
    end
    while (sb_q.size() > 0 && obs_q.size() > 0) begin
      check(name, 32'(obs_q.pop_front()), 32'(sb_q.pop_front()));
    end
    check({name, "_extra"}, 32'(obs_q.size()), 32'd0);
    sb_q.delete();
    obs_q.delete();
  endtask

  function automatic vec_t mk(input int bclk, input int cpbv, input bit pen, input bit podd,
                              input bit two, input logic [7:0] data, input bit pbit, input bit s1,
                              input bit s2, input bit eperr, input bit eferr, input logic [7:0] ebyte);
    vec_t v;
    v.bclk = bclk;
    v.cpb  = 16'(cpbv);
    v.pen  = pen;
    v.podd = podd;
    v.two  = two;
    v.data = data;
    v.pbit = pbit;
    v.s1   = s1;
    v.s2   = s2;
    v.want = {eperr, eferr, ebyte};
    return v;
  endfunction

  initial begin
    vec_t vecs[11];
    int   v0, o0, b0;

    //          bclk cpb pen podd two data   pbit s1 s2 perr ferr byte
    vecs[0]  = mk(16, 16, 0, 0, 0, 8'hA5, 0, 1, 1, 0, 0, 8'hA5);
    vecs[1]  = mk( 8,  8, 1, 0, 0, 8'h5A, 0, 1, 1, 0, 0, 8'h5A);
    vecs[2]  = mk( 8,  8, 1, 0, 0, 8'h5A, 1, 1, 1, 1, 0, 8'h5A);
    vecs[3]  = mk(10, 10, 0, 0, 1, 8'h3C, 0, 1, 0, 0, 1, 8'h3C);
    vecs[4]  = mk( 8,  8, 1, 1, 0, 8'h01, 0, 1, 1, 0, 0, 8'h01);
    vecs[5]  = mk( 8,  8, 1, 1, 0, 8'h01, 1, 1, 1, 1, 0, 8'h01);
    vecs[6]  = mk( 4,  3, 0, 0, 0, 8'h55, 0, 1, 1, 0, 0, 8'h55);
    vecs[7]  = mk( 8,  8, 0, 0, 0, 8'h81, 0, 0, 1, 0, 1, 8'h81);
    vecs[8]  = mk( 8,  8, 1, 0, 0, 8'h00, 1, 0, 1, 1, 1, 8'h00);
    vecs[9]  = mk(12, 12, 0, 0, 1, 8'h00, 0, 1, 1, 0, 0, 8'h00);
    vecs[10] = mk( 8,  8, 0, 0, 1, 8'hFF, 0, 0, 1, 0, 1, 8'hFF);

    rst = 1'b1;
    rx_line = 1'b1;
    cpb = 16'd16;
    par_en = 1'b0;
    par_odd = 1'b0;
    two_stop = 1'b0;
    rx_bus.i_Rx_Ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", rx_bus.o_Rx_Valid, 0);
    check("reset_outputs", {rx_bus.o_Rx_Byte, rx_bus.o_Parity_Err, rx_bus.o_Frame_Err, ovr, brk, busy}, 0);
    rst = 1'b0;
    rx_bus.i_Rx_Ready = 1'b1;
    hold(1'b1, 4);

    for (int i = 0; i < 11; i++) begin
      cpb = vecs[i].cpb;
      par_en = vecs[i].pen;
      par_odd = vecs[i].podd;
      two_stop = vecs[i].two;
      v0 = vhi_cnt;
      sb_q.push_back(vecs[i].want);
      send_frame(vecs[i].bclk, vecs[i].data, vecs[i].pen, vecs[i].pbit, vecs[i].two,
                 vecs[i].s1, vecs[i].s2);
      drain($sformatf("vec%0d", i), 200);
      if (i == 0) begin
        // start edge + 2 sync + IDLE detect + half bit (8) + 9 full bits of 16
        check("t1_latency", 32'(rise_cyc - start_cyc), 32'd155);
        check("t1_valid_cycles", 32'(vhi_cnt - v0), 32'd1);
      end
    end

    // FIFO fill with consumer stalled: fifth character overruns
    cpb = 16'd8;
    par_en = 1'b0;
    two_stop = 1'b0;
    rx_bus.i_Rx_Ready = 1'b0;
    o0 = ovr_cnt;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) sb_q.push_back({2'b00, 8'(k)});
      send_frame(8, 8'(k), 0, 0, 0, 1, 1);
    end
    check("ovr_pulse", 32'(ovr_cnt - o0), 32'd1);
    check("ovr_head_valid", rx_bus.o_Rx_Valid, 1);
    check("ovr_head_byte", rx_bus.o_Rx_Byte, 8'h01);
    check("ovr_no_pop", 32'(obs_q.size()), 32'd0);
    rx_bus.i_Rx_Ready = 1'b1;
    drain("ovr_drain", 50);
    check("ovr_empty", rx_bus.o_Rx_Valid, 0);

    // Break: line low for 12 bit times
    b0 = brk_cnt;
    hold(1'b0, 96);
    check("brk_pulse", 32'(brk_cnt - b0), 32'd1);
    check("brk_busy", busy, 1);
    check("brk_no_push", rx_bus.o_Rx_Valid, 0);
    hold(1'b1, 5);
    check("brk_idle", busy, 0);
    sb_q.push_back({2'b00, 8'h7E});
    send_frame(8, 8'h7E, 0, 0, 0, 1, 1);
    drain("brk_next", 200);

    // Short low glitch must be rejected at the start-bit midpoint
    cpb = 16'd16;
    o0 = ovr_cnt;
    b0 = brk_cnt;
    hold(1'b0, 3);
    rx_line = 1'b1;
    @(negedge clk);
    check("glitch_busy", busy, 1);
    @(posedge clk);
    #1;
    hold(1'b1, 30);
    check("glitch_idle", busy, 0);
    check("glitch_no_push", rx_bus.o_Rx_Valid, 0);
    check("glitch_flags", 32'((ovr_cnt - o0) + (brk_cnt - b0)), 32'd0);

    // Reset mid-DATA with a character waiting in the FIFO
    cpb = 16'd8;
    rx_bus.i_Rx_Ready = 1'b0;
    send_frame(8, 8'h11, 0, 0, 0, 1, 1);
    check("rst_pre_valid", rx_bus.o_Rx_Valid, 1);
    hold(1'b0, 8);
    hold(1'b1, 8);
    hold(1'b1, 8);
    hold(1'b0, 4);
    check("rst_mid_busy", busy, 1);
    rst = 1'b1;
    rx_line = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_valid", rx_bus.o_Rx_Valid, 0);
    check("rst_mid_outputs", {rx_bus.o_Rx_Byte, rx_bus.o_Parity_Err, rx_bus.o_Frame_Err, ovr, brk, busy}, 0);
    rx_bus.i_Rx_Ready = 1'b1;
    hold(1'b1, 16);
    sb_q.push_back({2'b00, 8'hC3});
    send_frame(8, 8'hC3, 0, 0, 0, 1, 1);
    drain("rst_next", 200);

    check("final_brk_total", 32'(brk_cnt), 32'd1);
    check("final_ovr_total", 32'(ovr_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the next generation of the bus UART RX path. It adds:
- runtime baud divisor
- 5..9 data bits
- optional even/odd parity
- 1 or 2 stop bits
- parity, framing, break and overrun detection
- small first-word-fall-through receive FIFO with valid/ready handshake

It sits between the external RX pin and the UART bus-slave register block, which pops characters and status.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
CNT_W, 16, width of baud divisor and bit-timing counter
FIFO_DEPTH, 4, receive FIFO entries (power of two, >=2)

Ports:
i_Clock  in  1  system clock
i_Reset  in  1  synchronous, active-high reset
i_Rx_Serial  in  1  asynchronous serial line, idle high
i_Clks_Per_Bit  in  CNT_W  clocks per bit; latched at start-bit detect; values <4 treated as 4
i_Parity_En  in  1  1 = parity bit follows data
i_Parity_Odd  in  1  1 = odd parity, 0 = even parity
i_Two_Stop  in  1  1 = two stop bits expected
o_Rx_Valid  out  1  FIFO head valid
i_Rx_Ready  in  1  consumer pops head when o_Rx_Valid & i_Rx_Ready
o_Rx_Byte  out  DATA_BITS  head data
o_Parity_Err  out  1  head frame had a parity mismatch
o_Frame_Err  out  1  head frame had a stop bit sampled low
o_Overrun  out  1  one-cycle pulse: a completed frame was dropped because the FIFO was full
o_Break  out  1  one-cycle pulse: break detected
o_Busy  out  1  state != IDLE

Behaviour:
- Reset (i_Reset high at a rising edge of i_Clock):
  - synchroniser flops set to 1; state IDLE; counters 0; FIFO empty
  - all outputs 0
  - reset mid-frame abandons the frame; nothing is pushed
- Synchroniser: 2 flops on i_Rx_Serial. All decisions use the second-stage value (rxs).
- Mode inputs i_Parity_En, i_Parity_Odd, i_Two_Stop and the divisor are latched with the divisor (D) in IDLE on start detect. Changes mid-frame have no effect.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT.
  - IDLE: rxs==0 -> START; cnt=0; latch D and modes.
  - START: at cnt==(D-1)>>1:
    - rxs==0 -> DATA, cnt=0, bit index=0
    - rxs==1 -> IDLE (glitch rejected; no flags)
    - otherwise cnt++
  - DATA: at cnt==D-1, sample rxs into data[idx], cnt=0. After DATA_BITS samples -> PARITY if parity enabled, else STOP1.
  - PARITY: at cnt==D-1, sample parity bit. Error when XOR(data, bit) != i_Parity_Odd. -> STOP1.
  - STOP1: at cnt==D-1, sample; rxs==0 sets frame_err. -> STOP2 if two stop bits, else complete.
  - STOP2: at cnt==D-1, sample; rxs==0 sets frame_err. -> complete.
- Complete, in the final stop-sample cycle:
  - Break condition: all data bits 0, parity bit (if any) 0, and every stop bit 0.
    - o_Break pulses on the next edge.
    - No FIFO push.
    - -> BRK_WAIT, which stays until rxs==1, then -> IDLE.
  - Otherwise: push {parity_err, frame_err, data}; -> IDLE.
  - Frame errors do not suppress the push.
- FIFO:
  - Push on the complete edge; o_Rx_Valid rises the next cycle. Total latency from the final stop-sample edge to o_Rx_Valid is 1 cycle.
  - Pop on o_Rx_Valid & i_Rx_Ready; the next entry appears on the following cycle.
  - Full, push without pop: frame dropped; o_Overrun pulses 1 cycle; stored entries untouched.
  - Full, push with pop in the same cycle: push accepted, count unchanged, no overrun.
  - Empty: o_Rx_Valid=0; i_Rx_Ready is ignored.
  - o_Rx_Byte and error outputs reflect the head entry whenever o_Rx_Valid=1. They are 0 when empty.
  - Pointers wrap modulo FIFO_DEPTH; count is held in a separate CNT register of width log2(FIFO_DEPTH)+1.
- Arithmetic:
  - cnt is CNT_W bits and never exceeds D-1.
  - Parity is computed over exactly DATA_BITS bits.

Test Plan:
1. D=16, 8N1, line sends 0xA5, i_Rx_Ready=1 -> o_Rx_Valid for 1 cycle with o_Rx_Byte=0xA5; both error outputs 0; valid rises 1 cycle after the stop-sample edge.
2. D=8, even parity; send 0x5A with parity bit 0, then 0x5A with parity bit 1 -> first entry o_Parity_Err=0, second o_Parity_Err=1; both have o_Rx_Byte=0x5A.
3. D=10, i_Two_Stop=1; send 0x3C with second stop bit low -> entry pushed with o_Frame_Err=1, o_Rx_Byte=0x3C.
4. i_Rx_Ready=0, FIFO_DEPTH=4; send 0x01..0x05 -> 0x05 dropped with a one-cycle o_Overrun pulse. Then raise i_Rx_Ready -> pops 0x01, 0x02, 0x03, 0x04 in order, then o_Rx_Valid=0.
5. Hold line low for 12 bit times, then release -> single o_Break pulse, no FIFO push, o_Busy=1 until the line is high, then a normal 0x7E frame is received correctly.
6. Line low for 3 cycles with D=16 -> returns to IDLE with no push or flags. Separately, assert i_Reset mid-DATA -> outputs 0, FIFO empty, next frame 0xC3 received correctly.
